onewire_master: RTL

ONEWIRE_MASTER -- requirements
Module: onewire_master

---
 rtl/onewire_pkg.sv | 33 +++
 rtl/onewire_sync.sv | 34 +++
 rtl/onewire_master.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared encodings and microsecond timing constants for the 1-Wire master.
package onewire_pkg;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RSV   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_WAIT = 3'd2,
    ST_SLOT_LOW = 3'd3,
    ST_SLOT_REL = 3'd4,
    ST_RECOVER  = 3'd5
  } state_e;

  localparam logic [9:0] T_RST_US  = 10'd480;
  localparam logic [9:0] T_PRES_US = 10'd70;
  localparam logic [9:0] T_W0_US   = 10'd60;
  localparam logic [9:0] T_W1_US   = 10'd6;
  localparam logic [9:0] T_RD_US   = 10'd15;
  localparam logic [9:0] T_SLOT_US = 10'd70;
  localparam logic [9:0] T_REC_US  = 10'd2;

  // Reads share the short write-1 low pulse, so callers pass wbit=1 for reads.
  function automatic logic [9:0] slot_low_us(input logic wbit);
    return wbit ? T_W1_US : T_W0_US;
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the asynchronous pad input.
// ONEWIRE_GLITCH_FILTER_EN adds a 3-sample majority filter clocked by the us tick.
module onewire_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_pad,
  output logic o_line
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], i_pad};
  end

`ifdef ONEWIRE_GLITCH_FILTER_EN
  logic [2:0] r_hist;

  // History starts at the idle (released, pulled-up) level.
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_hist <= 3'b111;
    else if (i_tick) r_hist <= {r_hist[1:0], r_sync[1]};
  end

  assign o_line = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
  logic w_unused_tick;
  assign w_unused_tick = i_tick;
  assign o_line        = r_sync[1];
`endif

endmodule

// File: rtl/onewire_master.sv
// 1-Wire bus master: reset/presence, write-bit and read-bit slots on an open-drain pad.
// Optional majority filter on the sampled line via ONEWIRE_GLITCH_FILTER_EN.
//
//   state       | meaning
//   ST_IDLE     | line released, waiting for a command
//   ST_RST_LOW  | reset pulse, line driven low
//   ST_RST_WAIT | line released, presence sampled
//   ST_SLOT_LOW | slot start, line driven low (long for write 0)
//   ST_SLOT_REL | line released, read bit sampled, slot runs out
//   ST_RECOVER  | inter-slot recovery, response issued on exit
module onewire_master
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  input  logic       i_cmd_wbit,
  output logic       o_cmd_ready,
  output logic       o_rsp_valid,
  output logic       o_rsp_bit,
  output logic       o_busy,
  input  logic       i_pad,
  output logic       o_pad_o,
  output logic       o_pad_t
);

  localparam logic [7:0] PRESC_TC = 8'(CLK_DIV - 1);

  state_e     r_state, w_next;
  logic [7:0] r_presc;
  logic [9:0] r_us, w_limit;
  logic       r_wbit, r_is_read, r_sample, r_rsv, r_rsp_hold;
  logic       w_tick, w_entry, w_done, w_accept, w_line, w_pad_t, w_rec_done;
  logic       w_samp_pres, w_samp_read, w_rsp_now;

  onewire_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tick  (w_tick),
    .i_pad   (i_pad),
    .o_line  (w_line)
  );

  assign w_tick   = (r_presc == PRESC_TC);
  assign w_entry  = (w_next != r_state);
  assign w_accept = i_cmd_valid && o_cmd_ready;

  // Prescaler restarts with the us counter so every phase is an exact multiple of CLK_DIV.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_entry) begin
      r_presc <= 8'd0;
      r_us    <= 10'd0;
    end else begin
      r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
      if (w_tick) r_us <= r_us + 10'd1;
    end
  end

  always_comb begin
    w_limit = 10'd0;
    case (r_state)
      ST_RST_LOW,
      ST_RST_WAIT: w_limit = T_RST_US;
      ST_SLOT_LOW: w_limit = slot_low_us(r_wbit);
      ST_SLOT_REL: w_limit = T_SLOT_US - slot_low_us(r_wbit);
      ST_RECOVER:  w_limit = T_REC_US;
      default:     w_limit = 10'd0;
    endcase
  end

  assign w_done = w_tick && (r_us == w_limit - 10'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pad_t    = 1'b1;
    w_rec_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_e'(i_cmd))
            CMD_RESET:          w_next = ST_RST_LOW;
            CMD_WRITE, CMD_READ: w_next = ST_SLOT_LOW;
            default:            w_next = ST_IDLE;
          endcase
        end
      end
      ST_RST_LOW: begin
        w_pad_t = 1'b0;
        if (w_done) w_next = ST_RST_WAIT;
      end
      ST_RST_WAIT: if (w_done) w_next = ST_RECOVER;
      ST_SLOT_LOW: begin
        w_pad_t = 1'b0;
        if (w_done) w_next = ST_SLOT_REL;
      end
      ST_SLOT_REL: if (w_done) w_next = ST_RECOVER;
      ST_RECOVER: begin
        if (w_done) begin
          w_next     = ST_IDLE;
          w_rec_done = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read sample lands 15 us after slot start; the read low phase is always the short one.
  assign w_samp_pres = (r_state == ST_RST_WAIT) && w_tick && (r_us == T_PRES_US - 10'd1);
  assign w_samp_read = (r_state == ST_SLOT_REL) && r_is_read && w_tick &&
                       (r_us == T_RD_US - T_W1_US - 10'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wbit     <= 1'b0;
      r_is_read  <= 1'b0;
      r_sample   <= 1'b0;
      r_rsv      <= 1'b0;
      r_rsp_hold <= 1'b0;
    end else begin
      r_rsv <= w_accept && (cmd_e'(i_cmd) == CMD_RSV);
      if (w_accept) begin
        r_is_read <= (cmd_e'(i_cmd) == CMD_READ);
        r_wbit    <= (cmd_e'(i_cmd) == CMD_READ) ? 1'b1 : i_cmd_wbit;
        r_sample  <= 1'b0;
      end else if (w_samp_pres) begin
        r_sample <= ~w_line;
      end else if (w_samp_read) begin
        r_sample <= w_line;
      end
      if (o_rsp_valid) r_rsp_hold <= w_rsp_now;
    end
  end

  assign w_rsp_now   = r_rsv ? 1'b0 : r_sample;
  assign o_rsp_valid = !i_reset && (w_rec_done || r_rsv);
  assign o_rsp_bit   = o_rsp_valid ? w_rsp_now : r_rsp_hold;
  assign o_cmd_ready = (r_state == ST_IDLE) && !i_reset;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_pad_o     = 1'b0;
  assign o_pad_t     = w_pad_t;

endmodule
